time_entry: RTL and testbench

TIME_ENTRY -- requirements
Module: time_entry

---
 rtl/time_entry_pkg.sv | 29 ++
 rtl/bcd_digit.sv | 33 +++
 rtl/time_entry.sv | 129 ++++++++++++
 tb/tb_time_entry.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/time_entry_pkg.sv
// Shared types and constants for the time_entry MM:SS editor.
package time_entry_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned BIN_W        = 6;
  localparam int unsigned CUR_W        = 2;
  localparam int unsigned TENS_MAX_DEF = 5;
  localparam int unsigned ONES_MAX_DEF = 9;

  localparam logic [CUR_W-1:0] CUR_M10 = 2'd0;
  localparam logic [CUR_W-1:0] CUR_M1  = 2'd1;
  localparam logic [CUR_W-1:0] CUR_S10 = 2'd2;
  localparam logic [CUR_W-1:0] CUR_S1  = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EDIT     = 3'd1,
    CONV_MIN = 3'd2,
    CONV_SEC = 3'd3,
    LOAD     = 3'd4
  } state_e;

  // tens*10 + ones as shifts; two BCD digits of at most 59 always fit in 6 bits
  function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [DIGIT_W-1:0] tens,
                                                  input logic [DIGIT_W-1:0] ones);
    return (BIN_W'(tens) << 3) + (BIN_W'(tens) << 1) + BIN_W'(ones);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit: 4-bit counter that wraps from MAX back to 0 on inc_en.
module bcd_digit
  import time_entry_pkg::*;
#(
  parameter int unsigned MAX = ONES_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc_en,
  output logic [DIGIT_W-1:0] value
);

  logic [DIGIT_W-1:0] value_q;
  logic [DIGIT_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (inc_en) begin
      value_d = (value_q >= DIGIT_W'(MAX)) ? '0 : value_q + DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/time_entry.sv
// MM:SS entry editor: cursor-driven BCD digit editing, then a staged BCD-to-binary commit.
module time_entry
  import time_entry_pkg::*;
#(
  parameter int unsigned TENS_MAX = TENS_MAX_DEF,
  parameter int unsigned ONES_MAX = ONES_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic               next,
  input  logic               inc,
  output logic [DIGIT_W-1:0] m10,
  output logic [DIGIT_W-1:0] m1,
  output logic [DIGIT_W-1:0] s10,
  output logic [DIGIT_W-1:0] s1,
  output logic [CUR_W-1:0]   cursor,
  output logic               editing,
  output logic [BIN_W-1:0]   minutes,
  output logic [BIN_W-1:0]   seconds,
  output logic               load
);

  state_e             state_q,       state_d;
  logic [CUR_W-1:0]   cursor_q,      cursor_d;
  logic [BIN_W-1:0]   minutes_tmp_q, minutes_tmp_d;
  logic [BIN_W-1:0]   seconds_tmp_q, seconds_tmp_d;
  logic [BIN_W-1:0]   minutes_q,     minutes_d;
  logic [BIN_W-1:0]   seconds_q,     seconds_d;
  logic               load_q,        load_d;
  logic               editing_q,     editing_d;
  logic [3:0]         inc_en;

  logic [DIGIT_W-1:0] m10_w, m1_w, s10_w, s1_w;

  bcd_digit #(.MAX(TENS_MAX)) u_m10 (
    .clk(clk), .reset(reset), .inc_en(inc_en[CUR_M10]), .value(m10_w)
  );
  bcd_digit #(.MAX(ONES_MAX)) u_m1 (
    .clk(clk), .reset(reset), .inc_en(inc_en[CUR_M1]), .value(m1_w)
  );
  bcd_digit #(.MAX(TENS_MAX)) u_s10 (
    .clk(clk), .reset(reset), .inc_en(inc_en[CUR_S10]), .value(s10_w)
  );
  bcd_digit #(.MAX(ONES_MAX)) u_s1 (
    .clk(clk), .reset(reset), .inc_en(inc_en[CUR_S1]), .value(s1_w)
  );

  // Next-state and datapath; in EDIT mode outranks next, which outranks inc
  always_comb begin
    state_d       = state_q;
    cursor_d      = cursor_q;
    minutes_tmp_d = minutes_tmp_q;
    seconds_tmp_d = seconds_tmp_q;
    minutes_d     = minutes_q;
    seconds_d     = seconds_q;
    inc_en        = '0;

    case (state_q)
      IDLE: begin
        if (mode) begin
          state_d  = EDIT;
          cursor_d = CUR_M10;
        end
      end
      EDIT: begin
        if (mode) begin
          state_d = CONV_MIN;
        end else if (next) begin
          cursor_d = cursor_q + CUR_W'(1);
        end else if (inc) begin
          inc_en[cursor_q] = 1'b1;
        end
      end
      CONV_MIN: begin
        minutes_tmp_d = bcd_to_bin(m10_w, m1_w);
        state_d       = CONV_SEC;
      end
      CONV_SEC: begin
        seconds_tmp_d = bcd_to_bin(s10_w, s1_w);
        state_d       = LOAD;
      end
      LOAD: begin
        minutes_d = minutes_tmp_q;
        seconds_d = seconds_tmp_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    load_d    = (state_d == LOAD);
    editing_d = (state_d == EDIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cursor_q      <= CUR_M10;
      minutes_tmp_q <= '0;
      seconds_tmp_q <= '0;
      minutes_q     <= '0;
      seconds_q     <= '0;
      load_q        <= 1'b0;
      editing_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cursor_q      <= cursor_d;
      minutes_tmp_q <= minutes_tmp_d;
      seconds_tmp_q <= seconds_tmp_d;
      minutes_q     <= minutes_d;
      seconds_q     <= seconds_d;
      load_q        <= load_d;
      editing_q     <= editing_d;
    end
  end

  assign m10     = m10_w;
  assign m1      = m1_w;
  assign s10     = s10_w;
  assign s1      = s1_w;
  assign cursor  = cursor_q;
  assign editing = editing_q;
  assign minutes = minutes_q;
  assign seconds = seconds_q;
  assign load    = load_q;

endmodule

// File: tb/tb_time_entry.sv
// Directed bench for time_entry; inputs driven and outputs sampled on the falling edge.
module tb_time_entry;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode, next, inc;
  logic [3:0] m10, m1, s10, s1;
  logic [1:0] cursor;
  logic       editing;
  logic [5:0] minutes, seconds;
  logic       load;

  int checks = 0;
  int errors = 0;

  time_entry #(.TENS_MAX(5), .ONES_MAX(9)) dut (
    .clk(clk), .reset(reset), .mode(mode), .next(next), .inc(inc),
    .m10(m10), .m1(m1), .s10(s10), .s1(s1), .cursor(cursor),
    .editing(editing), .minutes(minutes), .seconds(seconds), .load(load)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input logic m, input logic n, input logic i);
    mode = m; next = n; inc = i;
    @(negedge clk);
    mode = 1'b0; next = 1'b0; inc = 1'b0;
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) pulse(1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_digits(input string tag, input int a, input int b, input int c, input int d);
    check({tag, ".m10"}, 32'(m10), 32'(a));
    check({tag, ".m1"},  32'(m1),  32'(b));
    check({tag, ".s10"}, 32'(s10), 32'(c));
    check({tag, ".s1"},  32'(s1),  32'(d));
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; next = 1'b0; inc = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_digits("rst", 0, 0, 0, 0);
    check("rst.cursor", 32'(cursor), 0);
    check("rst.editing", 32'(editing), 0);
    check("rst.load", 32'(load), 0);
    check("rst.minutes", 32'(minutes), 0);
    check("rst.seconds", 32'(seconds), 0);

    // inc/next ignored in IDLE
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    check_digits("idle", 0, 0, 0, 0);
    check("idle.cursor", 32'(cursor), 0);
    check("idle.load", 32'(load), 0);
    check("idle.editing", 32'(editing), 0);

    // Enter edit, key in 37:42
    pulse(1'b1, 1'b0, 1'b0);
    check("edit.editing", 32'(editing), 1);
    check("edit.cursor", 32'(cursor), 0);
    incs(3); pulse(1'b0, 1'b1, 1'b0);
    incs(7); pulse(1'b0, 1'b1, 1'b0);
    incs(4); pulse(1'b0, 1'b1, 1'b0);
    incs(2);
    check_digits("3742", 3, 7, 4, 2);
    check("3742.cursor", 32'(cursor), 3);

    // Commit latency: load high in the third cycle after the mode edge
    pulse(1'b1, 1'b0, 1'b0);
    check("c1.editing", 32'(editing), 0);
    check("c1.load", 32'(load), 0);
    tick();
    check("c2.load", 32'(load), 0);
    tick();
    check("c3.load", 32'(load), 1);
    check("c3.minutes_hold", 32'(minutes), 0);
    tick();
    check("c4.load", 32'(load), 0);
    check("c4.minutes", 32'(minutes), 37);
    check("c4.seconds", 32'(seconds), 42);
    check("c4.cursor_hold", 32'(cursor), 3);

    // Digit wrap and cursor wrap
    pulse(1'b1, 1'b0, 1'b0);
    check("wrap.cursor0", 32'(cursor), 0);
    incs(2);
    check("wrap.m10_5", 32'(m10), 5);
    incs(1);
    check("wrap.m10_0", 32'(m10), 0);
    repeat (3) pulse(1'b0, 1'b1, 1'b0);
    check("wrap.cursor3", 32'(cursor), 3);
    incs(7);
    check("wrap.s1_9", 32'(s1), 9);
    incs(1);
    check("wrap.s1_0", 32'(s1), 0);
    pulse(1'b0, 1'b1, 1'b0);
    check("wrap.cursor_rolls", 32'(cursor), 0);

    // Coincident pulses: next beats inc, mode beats inc
    pulse(1'b0, 1'b1, 1'b1);
    check("prio.cursor", 32'(cursor), 1);
    check_digits("prio_ni", 0, 7, 4, 0);
    pulse(1'b1, 1'b0, 1'b1);
    check("prio.editing", 32'(editing), 0);
    check_digits("prio_mi", 0, 7, 4, 0);
    // Inputs held during conversion are ignored
    next = 1'b1; inc = 1'b1;
    tick();
    tick();
    check("conv.load", 32'(load), 1);
    next = 1'b0; inc = 1'b0;
    tick();
    check("conv.minutes", 32'(minutes), 7);
    check("conv.seconds", 32'(seconds), 40);
    check("conv.cursor", 32'(cursor), 1);
    check_digits("conv", 0, 7, 4, 0);

    // Reset in CONV_SEC aborts the commit
    pulse(1'b1, 1'b0, 1'b0);
    incs(1);
    pulse(1'b1, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("abort.load%0d", k), 32'(load), 0);
      tick();
    end
    check_digits("abort", 0, 0, 0, 0);
    check("abort.cursor", 32'(cursor), 0);
    check("abort.editing", 32'(editing), 0);
    check("abort.minutes", 32'(minutes), 0);
    check("abort.seconds", 32'(seconds), 0);

    // Commit 59:59
    pulse(1'b1, 1'b0, 1'b0);
    incs(5); pulse(1'b0, 1'b1, 1'b0);
    incs(9); pulse(1'b0, 1'b1, 1'b0);
    incs(5); pulse(1'b0, 1'b1, 1'b0);
    incs(9);
    pulse(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    check("max.load", 32'(load), 1);
    tick();
    check("max.minutes", 32'(minutes), 59);
    check("max.seconds", 32'(seconds), 59);

    // Re-enter and leave immediately: digits retained, same values reload
    pulse(1'b1, 1'b0, 1'b0);
    check("re.editing", 32'(editing), 1);
    check_digits("re", 5, 9, 5, 9);
    pulse(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    check("re.load", 32'(load), 1);
    tick();
    check("re.load_off", 32'(load), 0);
    check("re.minutes", 32'(minutes), 59);
    check("re.seconds", 32'(seconds), 59);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
